// File: rtl/mac_lane_pkg.sv
// mac_lane_pkg: lane config bit layout, output shift decode and saturation select for mac_lane_array
package mac_lane_pkg;
    localparam int CFG_MODE = 0;
    localparam int CFG_SIGNED = 1;
    localparam int CFG_SHIFT_LO = 2;
    localparam int CFG_SHIFT_HI = 3;

    function automatic logic [4:0] shift_amt(input logic [1:0] code);
        return code == 2'd0 ? 5'd0 : code == 2'd1 ? 5'd4 : code == 2'd2 ? 5'd8 : 5'd16;
    endfunction

    // Returns 2'b01 to clamp high, 2'b10 to clamp low, 2'b00 to keep the raw sum x+y=s.
    function automatic logic [1:0] sat_sel(input logic sgn, input logic x_msb, input logic y_msb,
                                           input logic s_msb, input logic carry);
        return !sgn ? {1'b0, carry} : (x_msb == y_msb && s_msb != x_msb) ? {x_msb, !x_msb} : 2'b00;
    endfunction
endpackage

// File: rtl/mac_lane_array_if.sv
// mac_lane_array_if: operand/result bus of mac_lane_array
interface mac_lane_array_if #(
    parameter int NUM_LANES = 4,
    parameter int MIN_WIDTH = 8,
    parameter int ACC_WIDTH = 32
);
    logic en, in_valid, acc_clr, out_valid;
    logic [NUM_LANES*MIN_WIDTH-1:0] a, b;
    logic [NUM_LANES*ACC_WIDTH-1:0] out;
    modport master(output en, in_valid, acc_clr, a, b, input out, out_valid);
    modport slave(input en, in_valid, acc_clr, a, b, output out, out_valid);
endinterface

// File: rtl/mac_lane.sv
// mac_lane: one lane's S2 stage (multiply, accumulate, output shift); MAC_LANE_SAT_EN makes MAC mode saturate
module mac_lane
    import mac_lane_pkg::*;
#(
    parameter int MIN_WIDTH = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 valid,
    input  logic                 clr,
    input  logic [3:0]           cfg,
    input  logic [MIN_WIDTH-1:0] a,
    input  logic [MIN_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] out
);
    logic sgn;
    logic [4:0] sh;
    logic [ACC_WIDTH-1:0] a_x, b_x, prod, base, sum, nxt, acc;
    logic signed [ACC_WIDTH-1:0] nxt_ash;

    assign sgn = cfg[CFG_SIGNED];
    assign sh = shift_amt(cfg[CFG_SHIFT_HI:CFG_SHIFT_LO]);
    // Extending the operands first makes one ACC-wide multiply exact for both signednesses.
    assign a_x = {{(ACC_WIDTH-MIN_WIDTH){sgn & a[MIN_WIDTH-1]}}, a};
    assign b_x = {{(ACC_WIDTH-MIN_WIDTH){sgn & b[MIN_WIDTH-1]}}, b};
    assign prod = a_x * b_x;
    assign base = clr ? '0 : acc;
`ifdef MAC_LANE_SAT_EN
    logic [ACC_WIDTH:0] sum_w;
    logic [1:0] sat;
    assign sum_w = {1'b0, base} + {1'b0, prod};
    assign sat = sat_sel(sgn, base[ACC_WIDTH-1], prod[ACC_WIDTH-1], sum_w[ACC_WIDTH-1], sum_w[ACC_WIDTH]);
    assign sum = sat[0] ? (sgn ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : '1)
               : sat[1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : sum_w[ACC_WIDTH-1:0];
`else
    assign sum = base + prod;
`endif
    assign nxt = cfg[CFG_MODE] ? sum : prod;
    assign nxt_ash = $signed(nxt) >>> sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            out <= '0;
        end else if (en && valid) begin
            acc <= nxt;
            out <= sgn ? nxt_ash : nxt >> sh;
        end else if (en && clr) begin
            acc <= '0;
        end
    end
endmodule

// File: rtl/mac_lane_array.sv
// mac_lane_array: NUM_LANES MAC lanes with scan-loaded per-lane config; MAC_LANE_SAT_EN enables MAC saturation
module mac_lane_array
    import mac_lane_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int MIN_WIDTH   = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int LANE_CONF_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic cset,
    input  logic shift_in,
    output logic shift_out,
    output logic cset_out,
    mac_lane_array_if.slave bus
);
    localparam int TOT = NUM_LANES * LANE_CONF_W;

    logic [TOT-1:0] shreg, active_cfg, s1_cfg;
    logic [NUM_LANES*MIN_WIDTH-1:0] s1_a, s1_b;
    logic s1_valid, s1_clr;

    assign shift_out = shreg[TOT-1];

    // Scan chain and active config ignore en; S1 snapshots the config so in-flight beats keep theirs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            active_cfg <= '0;
            cset_out <= 1'b0;
            s1_cfg <= '0;
            s1_a <= '0;
            s1_b <= '0;
            s1_valid <= 1'b0;
            s1_clr <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (cen) shreg <= {shreg[TOT-2:0], shift_in};
            if (cset) active_cfg <= shreg;
            cset_out <= cset;
            if (bus.en) begin
                s1_cfg <= active_cfg;
                s1_a <= bus.a;
                s1_b <= bus.b;
                s1_valid <= bus.in_valid;
                s1_clr <= bus.acc_clr;
                bus.out_valid <= s1_valid;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_lane #(.MIN_WIDTH(MIN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
            .clk(clk),
            .rst(rst),
            .en(bus.en),
            .valid(s1_valid),
            .clr(s1_clr),
            .cfg(s1_cfg[i*LANE_CONF_W +: LANE_CONF_W]),
            .a(s1_a[i*MIN_WIDTH +: MIN_WIDTH]),
            .b(s1_b[i*MIN_WIDTH +: MIN_WIDTH]),
            .out(bus.out[i*ACC_WIDTH +: ACC_WIDTH])
        );
    end
endmodule

// File: tb/tb_mac_lane_array.sv
// tb_mac_lane_array: directed scoreboard bench for mac_lane_array (expectations follow MAC_LANE_SAT_EN)
module tb_mac_lane_array;
    localparam int NL = 4;
    localparam int MW = 8;
    localparam int AW = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic cen = 1'b0, cset = 1'b0, shift_in = 1'b0, shift_out, cset_out;
    logic cen2 = 1'b0, cset2 = 1'b0, shift_in2 = 1'b0, shift_out2, cset_out2;
    logic en_prev = 1'b0;
    int total = 0, bad = 0;
    logic [15:0] m_shreg = '0, m_cfg = '0;
    longint m_acc [NL];
    logic [NL*AW-1:0] sbq [$];
    logic [NL*AW-1:0] last_push, exp_v, e1;
    logic [31:0] ra, rb;
    logic [3:0] cfg2 = 4'b0001;

    always #5 clk = ~clk;

    mac_lane_array_if #(.NUM_LANES(NL), .MIN_WIDTH(MW), .ACC_WIDTH(AW)) bus ();
    mac_lane_array_if #(.NUM_LANES(1), .MIN_WIDTH(MW), .ACC_WIDTH(16)) bus2 ();

    mac_lane_array #(.NUM_LANES(NL), .MIN_WIDTH(MW), .ACC_WIDTH(AW), .LANE_CONF_W(4)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cset(cset), .shift_in(shift_in),
        .shift_out(shift_out), .cset_out(cset_out), .bus(bus)
    );

    mac_lane_array #(.NUM_LANES(1), .MIN_WIDTH(MW), .ACC_WIDTH(16), .LANE_CONF_W(4)) dut2 (
        .clk(clk), .rst(rst), .cen(cen2), .cset(cset2), .shift_in(shift_in2),
        .shift_out(shift_out2), .cset_out(cset_out2), .bus(bus2)
    );

    always @(posedge clk) en_prev <= bus.en;

    function automatic longint sx(input longint v, input int w);
        return v >= (longint'(1) << (w - 1)) ? v - (longint'(1) << w) : v;
    endfunction

    function automatic longint lane_acc(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                                        input longint base, input int w);
        longint p, s, m, lo, hi;
        m = (longint'(1) << w) - 1;
        p = c[1] ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
        if (!c[0]) return p & m;
        s = c[1] ? sx(base, w) + p : base + p;
`ifdef MAC_LANE_SAT_EN
        lo = c[1] ? -(longint'(1) << (w - 1)) : 0;
        hi = c[1] ? (longint'(1) << (w - 1)) - 1 : m;
        s = s > hi ? hi : s < lo ? lo : s;
`else
        lo = 0;
        hi = m;
`endif
        return s & m;
    endfunction

    function automatic longint lane_out(input logic [3:0] c, input longint acc, input int w);
        int sh;
        sh = c[3:2] == 2'd0 ? 0 : c[3:2] == 2'd1 ? 4 : c[3:2] == 2'd2 ? 8 : 16;
        return (c[1] ? sx(acc, w) >>> sh : acc >> sh) & ((longint'(1) << w) - 1);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_beat(input logic v, input logic clr, input logic [31:0] av, input logic [31:0] bv);
        logic [NL*AW-1:0] vec;
        vec = '0;
        for (int i = 0; i < NL; i++) begin
            if (v) begin
                m_acc[i] = lane_acc(m_cfg[4*i +: 4], av[8*i +: 8], bv[8*i +: 8], clr ? 0 : m_acc[i], AW);
                vec[AW*i +: AW] = 32'(lane_out(m_cfg[4*i +: 4], m_acc[i], AW));
            end else begin
                m_acc[i] = 0;
            end
        end
        if (v) begin
            sbq.push_back(vec);
            last_push = vec;
        end
    endtask

    task automatic cyc(input logic v, input logic clr, input logic e, input logic cs,
                       input logic [31:0] av, input logic [31:0] bv);
        bus.en = e;
        bus.in_valid = v;
        bus.acc_clr = clr;
        bus.a = av;
        bus.b = bv;
        cset = cs;
        if (e && (v || clr)) model_beat(v, clr, av, bv);
        step();
        if (cs) m_cfg = m_shreg;
        cset = 1'b0;
        bus.en = 1'b1;
        bus.in_valid = 1'b0;
        bus.acc_clr = 1'b0;
    endtask

    task automatic scan(input logic [15:0] v);
        for (int k = 15; k >= 0; k--) begin
            chk("shift_out", shift_out, m_shreg[15]);
            cen = 1'b1;
            shift_in = v[k];
            step();
            m_shreg = {m_shreg[14:0], v[k]};
        end
        cen = 1'b0;
    endtask

    task automatic rnd_beat(input logic clr);
        ra = $urandom();
        rb = $urandom();
        cyc(1'b1, clr, 1'b1, 1'b0, ra, rb);
    endtask

    always @(negedge clk) begin
        if (!rst && en_prev && bus.out_valid) begin
            total++;
            assert (sbq.size() != 0) else begin
                bad++;
                $error("FAIL sb_spurious got=%h exp=queued", bus.out);
            end
            if (sbq.size() != 0) begin
                exp_v = sbq.pop_front();
                assert (bus.out === exp_v) else begin
                    bad++;
                    $error("FAIL sb_out got=%h exp=%h", bus.out, exp_v);
                end
            end
        end
    end

    initial begin
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.acc_clr = 1'b0; bus.a = '0; bus.b = '0;
        bus2.en = 1'b1; bus2.in_valid = 1'b0; bus2.acc_clr = 1'b0; bus2.a = '0; bus2.b = '0;
        for (int i = 0; i < NL; i++) m_acc[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out", bus.out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_shift_out", shift_out, 0);
        chk("rst_cset_out", cset_out, 0);
        chk("rst_out2", bus2.out, 0);

        // scan/set: every lane unsigned MAC, shift 0
        scan(16'h1111);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("cset_out_hi", cset_out, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("cset_out_lo", cset_out, 0);

        // MAC latency and lane0 12 then 42
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, {ra[31:8], 8'd3}, {rb[31:8], 8'd4});
        chk("mac_ov_n1", bus.out_valid, 0);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {ra[31:8], 8'd5}, {rb[31:8], 8'd6});
        chk("mac_ov_n2", bus.out_valid, 1);
        chk("mac_out0_12", bus.out[31:0], 12);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("mac_ov_n3", bus.out_valid, 1);
        chk("mac_out0_42", bus.out[31:0], 42);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("mac_ov_idle", bus.out_valid, 0);

        // signed multiply, then arithmetic shift by 4
        scan(16'h5CB2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, {ra[31:8], 8'hFF}, {rb[31:8], 8'h02});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("smul_out0", bus.out[31:0], 32'hFFFF_FFFE);
        repeat (4) rnd_beat(1'b0);
        scan(16'h5CB6);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {ra[31:8], 8'hFF}, {rb[31:8], 8'h02});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("smul_shift_out0", bus.out[31:0], 32'hFFFF_FFFF);

        // stall three cycles with junk on the inputs
        rnd_beat(1'b1);
        e1 = last_push;
        rnd_beat(1'b0);
        for (int k = 0; k < 3; k++) begin
            ra = $urandom(); rb = $urandom();
            cyc(1'b1, 1'b1, 1'b0, 1'b0, ra, rb);
            chk("stall_out", bus.out, e1);
            chk("stall_ov", bus.out_valid, 1);
        end
        rnd_beat(1'b0);
        rnd_beat(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

        // config change while a beat is in flight
        scan(16'h1111);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, {ra[31:8], 8'd1}, {rb[31:8], 8'd1});
        scan(16'h0000);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {ra[31:8], 8'd2}, {rb[31:8], 8'd3});
        cyc(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("inflight_old_mac", bus.out[31:0], 7);
        ra = $urandom(); rb = $urandom();
        cyc(1'b1, 1'b0, 1'b1, 1'b0, {ra[31:8], 8'd4}, {rb[31:8], 8'd5});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("inflight_new_mult", bus.out[31:0], 20);

        // 16-bit unsigned MAC overflow on the single-lane instance
        for (int k = 3; k >= 0; k--) begin
            cen2 = 1'b1;
            shift_in2 = cfg2[k];
            step();
        end
        cen2 = 1'b0;
        cset2 = 1'b1;
        step();
        cset2 = 1'b0;
        bus2.in_valid = 1'b1; bus2.acc_clr = 1'b1; bus2.a = 8'd255; bus2.b = 8'd255;
        step();
        bus2.acc_clr = 1'b0;
        step();
        bus2.in_valid = 1'b0;
        chk("ovf_first", bus2.out, 16'hFE01);
        step();
`ifdef MAC_LANE_SAT_EN
        chk("ovf_second", bus2.out, 16'hFFFF);
`else
        chk("ovf_second", bus2.out, 16'hFC02);
`endif
        chk("ovf_ov", bus2.out_valid, 1);

        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        chk("sb_drain", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
